// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and types for the 640x480@60Hz raster generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int MAX_TOTAL      = 1 << COORD_W;
  localparam int MAX_SYNC_DELAY = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  // Half-open window test done in int so a bound equal to 2**COORD_W cannot wrap.
  function automatic logic in_window(coord_t pos, int lo, int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-width (2-bit) shift register that delays hs/vs to match the renderer RGB latency.
module sync_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    wire unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [1:0] stages [DEPTH];

    // NOTE: every stage is reset (unlike a data RAM) so sync reads inactive until real samples arrive.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= '1;
      end else begin
        stages[0] <= d;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign q = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY counters, blank, delayed hs/vs and frame strobes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_DELAY = 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               frame_start,
  output logic               vblank_start
`ifdef VGA_FRAME_COUNT_EN
  ,output logic [7:0]        frame_count
`endif
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed %0d", MAX_TOTAL);
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 0..%0d", MAX_SYNC_DELAY);
  end

  coord_t hc;
  coord_t vc;
  logic   line_end;
  logic   frame_end;
  sync_t  sync_raw;
  sync_t  sync_dly;

  assign line_end  = (int'(hc) == H_TOTAL - 1);
  assign frame_end = line_end && (int'(vc) == V_TOTAL - 1);

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= coord_t'(H_TOTAL - 1);
      vc <= coord_t'(V_TOTAL - 1);
    end else if (line_end) begin
      hc <= '0;
      vc <= frame_end ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign DrawX        = hc;
  assign DrawY        = vc;
  assign blank        = in_window(hc, 0, H_VISIBLE) && in_window(vc, 0, V_VISIBLE);
  assign frame_start  = (hc == '0) && (vc == '0);
  assign vblank_start = (hc == '0) && (int'(vc) == V_VISIBLE);

  assign sync_raw.hs = !in_window(hc, HS_START, HS_END);
  assign sync_raw.vs = !in_window(vc, VS_START, VS_END);

  sync_delay_line #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     (sync_raw),
    .q     (sync_dly)
  );

  assign hs = sync_dly.hs;
  assign vs = sync_dly.vs;

`ifdef VGA_FRAME_COUNT_EN
  // Advances on the wrap into (0,0), i.e. the same edge that raises frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 8'd0;
    end else if (frame_end) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: full 640x480 instance plus two shrunken-raster instances (SYNC_DELAY 0 and 4).
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hfp; int hsw; int hbp;
    int vv; int vfp; int vsw; int vbp;
    int sd;
  } cfg_t;

  localparam cfg_t FULL = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  localparam cfg_t S0   = '{8, 2, 3, 3, 4, 1, 1, 2, 0};
  localparam cfg_t S4   = '{8, 2, 3, 3, 4, 1, 1, 2, 4};

  logic vga_clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;   // clock edges taken since the last reset release

  always #5 vga_clk = ~vga_clk;

  logic [9:0] f_x, f_y, a_x, a_y, b_x, b_y;
  logic       f_bl, f_hs, f_vs, f_fs, f_vb;
  logic       a_bl, a_hs, a_vs, a_fs, a_vb;
  logic       b_bl, b_hs, b_vs, b_fs, b_vb;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] f_fc, a_fc, b_fc;
`endif

  vga_timing_gen #(
    .H_VISIBLE(FULL.hv), .H_FP(FULL.hfp), .H_SYNC(FULL.hsw), .H_BP(FULL.hbp),
    .V_VISIBLE(FULL.vv), .V_FP(FULL.vfp), .V_SYNC(FULL.vsw), .V_BP(FULL.vbp),
    .SYNC_DELAY(FULL.sd)
  ) u_full (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(f_x), .DrawY(f_y), .blank(f_bl),
    .hs(f_hs), .vs(f_vs), .frame_start(f_fs), .vblank_start(f_vb)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(f_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(S0.hv), .H_FP(S0.hfp), .H_SYNC(S0.hsw), .H_BP(S0.hbp),
    .V_VISIBLE(S0.vv), .V_FP(S0.vfp), .V_SYNC(S0.vsw), .V_BP(S0.vbp),
    .SYNC_DELAY(S0.sd)
  ) u_s0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
    .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .vblank_start(a_vb)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(S4.hv), .H_FP(S4.hfp), .H_SYNC(S4.hsw), .H_BP(S4.hbp),
    .V_VISIBLE(S4.vv), .V_FP(S4.vfp), .V_SYNC(S4.vsw), .V_BP(S4.vbp),
    .SYNC_DELAY(S4.sd)
  ) u_s4 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
    .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .vblank_start(b_vb)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  // Reference model: raster position is simply the edge count modulo the frame length,
  // with the reset state sitting one pixel before (0,0).
  function automatic int h_total(cfg_t c);
    return c.hv + c.hfp + c.hsw + c.hbp;
  endfunction

  function automatic int v_total(cfg_t c);
    return c.vv + c.vfp + c.vsw + c.vbp;
  endfunction

  function automatic int raster_idx(cfg_t c, int kk);
    int f;
    f = h_total(c) * v_total(c);
    return (kk + f - 1) % f;
  endfunction

  function automatic logic model_hs(cfg_t c, int kk);
    int x;
    if (kk < 0) return 1'b1;
    x = raster_idx(c, kk) % h_total(c);
    return !(x >= c.hv + c.hfp && x < c.hv + c.hfp + c.hsw);
  endfunction

  function automatic logic model_vs(cfg_t c, int kk);
    int y;
    if (kk < 0) return 1'b1;
    y = raster_idx(c, kk) / h_total(c);
    return !(y >= c.vv + c.vfp && y < c.vv + c.vfp + c.vsw);
  endfunction

  function automatic int model_fc(cfg_t c, int kk);
    if (kk == 0) return 0;
    return ((kk - 1) / (h_total(c) * v_total(c)) + 1) % 256;
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, observed, expected);
    end
  endtask

  task automatic check_dut(string name, cfg_t c, logic [9:0] dx, logic [9:0] dy,
                           logic bl, logic h, logic v, logic fs, logic vb);
    int n, x, y;
    n = raster_idx(c, k);
    x = n % h_total(c);
    y = n / h_total(c);
    check({name, ".DrawX"},        32'(dx), x);
    check({name, ".DrawY"},        32'(dy), y);
    check({name, ".blank"},        32'(bl), 32'(x < c.hv && y < c.vv));
    check({name, ".hs"},           32'(h),  32'(model_hs(c, k - c.sd)));
    check({name, ".vs"},           32'(v),  32'(model_vs(c, k - c.sd)));
    check({name, ".frame_start"},  32'(fs), 32'(n == 0));
    check({name, ".vblank_start"}, 32'(vb), 32'(x == 0 && y == c.vv));
  endtask

  task automatic check_all();
    check_dut("full", FULL, f_x, f_y, f_bl, f_hs, f_vs, f_fs, f_vb);
    check_dut("s0",   S0,   a_x, a_y, a_bl, a_hs, a_vs, a_fs, a_vb);
    check_dut("s4",   S4,   b_x, b_y, b_bl, b_hs, b_vs, b_fs, b_vb);
`ifdef VGA_FRAME_COUNT_EN
    check("full.frame_count", 32'(f_fc), model_fc(FULL, k));
    check("s4.frame_count",   32'(b_fc), model_fc(S4, k));
`endif
  endtask

  task automatic tick();
    @(posedge vga_clk);
    if (reset_n) k++;
    #1;
    check_all();
  endtask

  initial begin
    int hs_low, vs_low, fs_seen, fs_gap, last_fs;
    reset_n = 1'b0;
    k = 0;

    // Reset held: parked at (799,524), sync inactive, no strobes.
    repeat (3) tick();
    #4 reset_n = 1'b1;

    // First full line: count hs-low clocks on the 640x480 instance.
    hs_low = 0;
    for (int i = 0; i < FULL.hv + FULL.hfp + FULL.hsw + FULL.hbp; i++) begin
      tick();
      if (f_hs === 1'b0) hs_low++;
    end
    check("full.hs_low_per_line", hs_low, FULL.hsw);
    tick();
    check("full.line1_DrawY", 32'(f_y), 1);

    // Several small frames: vs width, frame_start count and period.
    vs_low = 0; fs_seen = 0; fs_gap = 0; last_fs = -1;
    for (int i = 0; i < 4 * h_total(S0) * v_total(S0); i++) begin
      tick();
      if (a_vs === 1'b0) vs_low++;
      if (a_fs === 1'b1) begin
        if (last_fs >= 0) fs_gap = k - last_fs;
        last_fs = k;
        fs_seen++;
      end
    end
    check("s0.vs_low_4_frames", vs_low, 4 * S0.vsw * h_total(S0));
    check("s0.frame_start_count", fs_seen, 4);
    check("s0.frame_period", fs_gap, h_total(S0) * v_total(S0));

    // Random asynchronous resets dropped between clock edges.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(500, 50)) tick();
      #($urandom_range(6, 1));
      reset_n = 1'b0;
      k = 0;
      #1 check_all();
      repeat ($urandom_range(3, 1)) tick();
      #4 reset_n = 1'b1;
    end

    // Long run covering 256+ small frames (frame counter wrap when enabled).
    repeat (256 * h_total(S4) * v_total(S4) + $urandom_range(40, 5)) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
